store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// CPU request/response and data-memory signals of the store buffer.
// slave is the buffer's side; master is the CPU/memory environment side.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [4:0]    req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [4:0]    dm_addr;
    logic [31:0]   dm_data;
    logic          dm_memWrite;
    logic          dm_memRead;
    logic [31:0]   dm_readData;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, dm_readData,
        output req_ready, rsp_valid, rsp_rdata, dm_addr, dm_data, dm_memWrite, dm_memRead,
               count, empty
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, dm_readData,
        input  req_ready, rsp_valid, rsp_rdata, dm_addr, dm_data, dm_memWrite, dm_memRead,
               count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Write-behind store buffer: stores queue in FIFO order and drain to memory one per idle cycle;
// loads forward from the youngest matching buffered store or read data memory.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    state_e        r_state, w_state_d;
    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_ld_addr;
    logic [31:0]   r_rdata;

    logic          w_full, w_accept, w_load, w_store, w_drain, w_hit;
    logic [31:0]   w_fwd_data;
    logic [PW-1:0] w_idx;

    assign w_full        = (r_count == CW'(DEPTH));
    assign bus.req_ready = reset && (r_state == StIdle) && (!bus.req_write || !w_full);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_load        = w_accept && !bus.req_write;
    assign w_store       = w_accept && bus.req_write;
    // An accepted load blocks the drain, so the whole buffer is searched below.
    assign w_drain       = (r_state == StIdle) && (r_count != '0) && !w_load;

    assign bus.count     = r_count;
    assign bus.empty     = (r_count == '0);
    assign bus.rsp_rdata = r_rdata;

    // Walk from head to tail; later hits overwrite earlier ones so the youngest wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx] == bus.req_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    always_comb begin
        w_state_d       = r_state;
        bus.rsp_valid   = 1'b0;
        bus.dm_addr     = '0;
        bus.dm_data     = '0;
        bus.dm_memWrite = 1'b0;
        bus.dm_memRead  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_load) w_state_d = w_hit ? StResp : StRead;
                if (w_drain) begin
                    bus.dm_memWrite = 1'b1;
                    bus.dm_addr     = r_addr[r_head];
                    bus.dm_data     = r_data[r_head];
                end
            end
            StRead: begin
                bus.dm_memRead = 1'b1;
                bus.dm_addr    = r_ld_addr;
                w_state_d      = StResp;
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                w_state_d     = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ld_addr <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_store) r_tail <= r_tail + PW'(1);
            if (w_drain) r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_store) - CW'(w_drain);
            if (w_load) begin
                r_ld_addr <= bus.req_addr;
                if (w_hit) r_rdata <= w_fwd_data;
            end
            if (r_state == StRead) r_rdata <= bus.dm_readData;
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_addr[r_tail] <= bus.req_addr;
            r_data[r_tail] <= bus.req_wdata;
        end
    end
endmodule
